hazard_stall_unit: RTL and testbench

//  Pipeline hazard controller; drives the PC's pcwrite enable and the IF/ID, ID/EX control.

---
 rtl/hazard_stall_unit.sv | 118 +++++++++++
 tb/tb_hazard_stall_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory freezes,
// plus saturating stall/flush performance counters.
module hazard_stall_unit #(
    parameter int REG_W          = 5,
    parameter int LOAD_USE_STALL = 1,   // legal range 1..7 (fits the 3-bit remaining counter)
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    output logic             pcwrite,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        ST_RUN,
        ST_LU_STALL
    } state_e;

    localparam logic [2:0]       STALL_EXTRA = 3'(LOAD_USE_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e           state_q, state_d;
    logic [2:0]       remaining_q, remaining_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             rs1_match, rs2_match, lu_hit, branch_fire;

    // x0 is hard-wired zero, so a load targeting it can never create a dependency.
    assign rs1_match   = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match   = id_uses_rs2 && (id_rs2 == ex_rd);
    assign lu_hit      = ex_memread && (ex_rd != '0) && (rs1_match || rs2_match);
    assign branch_fire = !reset && !dmem_busy && ex_branch_taken;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pcwrite     = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (reset) begin
            pcwrite     = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = ST_RUN;
            remaining_d = '0;
        end else if (dmem_busy) begin
            // Freeze everything; a coincident branch waits until memory is ready.
            pcwrite     = 1'b0;
            if_id_write = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = ST_RUN;
            remaining_d = '0;
        end else if (state_q == ST_LU_STALL) begin
            pcwrite     = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if (remaining_q <= 3'd1) begin
                state_d     = ST_RUN;
                remaining_d = '0;
            end else begin
                remaining_d = remaining_q - 3'd1;
            end
        end else if (lu_hit) begin
            pcwrite     = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if (LOAD_USE_STALL > 1) begin
                state_d     = ST_LU_STALL;
                remaining_d = STALL_EXTRA;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!reset && !pcwrite && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (branch_fire && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            remaining_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: two instances (default, and 3-cycle stall with 4-bit
// counters) share stimulus; a behavioural model queues expected per-cycle responses.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_memread = 1'b0;
    logic       ex_branch_taken = 1'b0, dmem_busy = 1'b0;

    logic        pcw_a, ifw_a, iff_a, idf_a;
    logic [15:0] stall_a, flush_a;
    logic        pcw_b, ifw_b, iff_b, idf_b;
    logic [3:0]  stall_b, flush_b;

    always #5 clk = ~clk;

    hazard_stall_unit u_a (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .pcwrite(pcw_a), .if_id_write(ifw_a), .if_id_flush(iff_a), .id_ex_flush(idf_a),
        .stall_cycles(stall_a), .flush_count(flush_a)
    );

    hazard_stall_unit #(.REG_W(5), .LOAD_USE_STALL(3), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .pcwrite(pcw_b), .if_id_write(ifw_b), .if_id_flush(iff_b), .id_ex_flush(idf_b),
        .stall_cycles(stall_b), .flush_count(flush_b)
    );

    typedef struct {
        logic [1:0][3:0]  ctl;   // {pcwrite, if_id_write, if_id_flush, id_ex_flush}
        logic [1:0][31:0] st;
        logic [1:0][31:0] fl;
        bit               cnt_known;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model state, per instance: extra stall cycles still owed and counter values.
    int   lu_len [2] = '{1, 3};
    int   cnt_max[2] = '{65535, 15};
    int   m_rem  [2] = '{0, 0};
    int   m_stall[2] = '{0, 0};
    int   m_flush[2] = '{0, 0};
    bit   cnt_known  = 1'b0;

    task automatic step(input bit r, input int rs1, input int rs2, input bit u1, input bit u2,
                        input bit mr, input int rd, input bit br, input bit bz);
        exp_t       e;
        bit         hit, stl, fl;
        logic [3:0] ctl;
        @(posedge clk);
        #1;
        reset = r; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_memread = mr; ex_rd = 5'(rd); ex_branch_taken = br; dmem_busy = bz;
        hit = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        for (int k = 0; k < 2; k++) begin
            stl = 1'b0;
            fl  = 1'b0;
            if (r) begin
                ctl = 4'b0011;
            end else if (bz) begin
                ctl = 4'b0000; stl = 1'b1;
            end else if (br) begin
                ctl = 4'b1111; fl = 1'b1; m_rem[k] = 0;
            end else if (m_rem[k] > 0) begin
                ctl = 4'b0001; stl = 1'b1; m_rem[k] = m_rem[k] - 1;
            end else if (hit) begin
                ctl = 4'b0001; stl = 1'b1; m_rem[k] = lu_len[k] - 1;
            end else begin
                ctl = 4'b1100;
            end
            e.ctl[k] = ctl;
            e.st[k]  = 32'(m_stall[k]);
            e.fl[k]  = 32'(m_flush[k]);
            if (r) begin
                m_stall[k] = 0; m_flush[k] = 0; m_rem[k] = 0;
            end else begin
                if (stl && m_stall[k] < cnt_max[k]) m_stall[k] = m_stall[k] + 1;
                if (fl && m_flush[k] < cnt_max[k])  m_flush[k] = m_flush[k] + 1;
            end
        end
        e.cnt_known = cnt_known;
        if (r) cnt_known = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s txn %0d: got %0d expected %0d", name, txn, act, req);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare mid-cycle against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ctl_a", int'({pcw_a, ifw_a, iff_a, idf_a}), int'(e.ctl[0]));
                chk("ctl_b", int'({pcw_b, ifw_b, iff_b, idf_b}), int'(e.ctl[1]));
                if (e.cnt_known) begin
                    chk("stall_a", int'(stall_a), int'(e.st[0]));
                    chk("flush_a", int'(flush_a), int'(e.fl[0]));
                    chk("stall_b", int'(stall_b), int'(e.st[1]));
                    chk("flush_b", int'(flush_b), int'(e.fl[1]));
                end
                $display("txn %0d rst=%0b ctl_a=%b st_a=%0d fl_a=%0d ctl_b=%b st_b=%0d fl_b=%0d",
                         txn, reset, {pcw_a, ifw_a, iff_a, idf_a}, stall_a, flush_a,
                         {pcw_b, ifw_b, iff_b, idf_b}, stall_b, flush_b);
                txn++;
            end
        end
    end

    initial begin
        // Reset for two clocks, then normal flow.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Single load-use hit on rs1.
        step(0, 5, 0, 1, 0, 1, 5, 0, 0);
        idle(4);
        // x0 never hazards; unused source never hazards.
        step(0, 0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 5, 0, 0, 0, 1, 5, 0, 0);
        step(0, 0, 7, 0, 1, 1, 7, 0, 0);
        idle(4);
        // Branch wins over a coincident load-use hit.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 5, 0, 1, 0, 1, 5, 1, 0);
        idle(2);
        // Busy freezes and defers a held branch.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // Multi-cycle stall, then reset during its second cycle.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 3, 0, 1, 0, 1, 3, 0, 0);
        idle(4);
        step(0, 3, 0, 1, 0, 1, 3, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Branch aborting a multi-cycle stall.
        step(0, 0, 2, 0, 1, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // Long busy run saturates the narrow counter.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // Randomized traffic with small register indices so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
